mem_port_arbiter: RTL

//  Shares the core's single external memory port between the IF stage (instruction fetch) and the MEM stage
//  (load/store). Grants one requester at a time, presents its transaction on the bus, returns the response,
//  and raises per-stage stalls to the pipeline. Discards an in-flight fetch response when a branch flushes IF.

---
 rtl/mem_port_arbiter_if.sv | 78 +++++++
 rtl/mem_port_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
//   Bundles the IF-stage, MEM-stage and external memory-bus signals handled
//   by mem_port_arbiter.
//
//   slave  modport : the arbiter itself. It takes requests from the pipeline
//                    and bus responses, and drives ready/rdata/stall and the
//                    registered bus request.
//   master modport : the surroundings of the arbiter, i.e. the IF and MEM
//                    stages plus the memory bus (or a testbench standing in
//                    for all of them).
//
//   Signals
//     if_req/if_addr          fetch request, held until if_ready or flush
//     if_rdata/if_ready       fetch response (1-cycle pulse)
//     flush                   branch taken, drops the pending/in-flight fetch
//     mem_req/we/wstrb/addr/wdata  data request, held until mem_ready
//     mem_rdata/mem_ready     data response (1-cycle pulse)
//     stall_IF/stall_MEM      per-stage stall towards the pipeline
//     bus_valid/we/wstrb/addr/wdata  registered bus request
//     bus_ack/bus_rdata       bus completion and read data
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  // IF stage
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;
  logic              flush;

  // MEM stage
  logic              mem_req;
  logic              mem_we;
  logic [STRB_W-1:0] mem_wstrb;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  // Stalls
  logic              stall_IF;
  logic              stall_MEM;

  // External memory bus
  logic              bus_valid;
  logic              bus_we;
  logic [STRB_W-1:0] bus_wstrb;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_ack;
  logic [DATA_W-1:0] bus_rdata;

  modport slave (
    input  if_req, if_addr, flush,
    input  mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata,
    input  bus_ack, bus_rdata,
    output if_rdata, if_ready,
    output mem_rdata, mem_ready,
    output stall_IF, stall_MEM,
    output bus_valid, bus_we, bus_wstrb, bus_addr, bus_wdata
  );

  modport master (
    output if_req, if_addr, flush,
    output mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata,
    output bus_ack, bus_rdata,
    input  if_rdata, if_ready,
    input  mem_rdata, mem_ready,
    input  stall_IF, stall_MEM,
    input  bus_valid, bus_we, bus_wstrb, bus_addr, bus_wdata
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares the core's single external memory port between instruction fetch
//   (IF stage) and load/store (MEM stage). One requester is granted at a time;
//   its transaction is registered onto the bus and held until bus_ack, the
//   response is handed back combinationally in the ack cycle, and per-stage
//   stalls are raised while a request is outstanding. A branch flush discards
//   the response of a fetch already on the bus.
//
//   Parameters
//     ADDR_W      address width
//     DATA_W      data width, multiple of 8
//     STARVE_MAX  consecutive MEM grants tolerated while a fetch waits (>=1)
//
//   Ports
//     clk    rising-edge clock
//     reset  asynchronous, active-high
//     mp     mem_port_arbiter_if.slave (IF, MEM and bus signals)
//
//   Arbitration happens only in IDLE. MEM wins unless the fetch has already
//   been passed over STARVE_MAX times in a row. Every access returns to IDLE
//   for at least one cycle, so an access takes at least 2 cycles and a
//   requester that keeps its request after ready is simply re-arbitrated.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.slave  mp
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_IF  = 2'd1,
    BUSY_MEM = 2'd2
  } state_e;

  state_e            state_q;
  logic              bus_valid_q;
  logic              bus_we_q;
  logic [STRB_W-1:0] bus_wstrb_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [DATA_W-1:0] bus_wdata_q;
  logic [CNT_W-1:0]  starve_cnt_q;
  logic [CNT_W-1:0]  starve_cnt_d;
  logic              drop_q;

  logic              if_starved;
  logic              grant_mem;
  logic              grant_if;
  logic              if_ack;
  logic              mem_ack;
  logic              if_ready_w;
  logic              mem_ready_w;

  // Saturating increment of the starvation counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v >= STARVE_LIM) begin
      return STARVE_LIM;
    end
    return v + CNT_W'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // Grant decision (IDLE only)
  // ---------------------------------------------------------------------------
  assign if_starved = mp.if_req && (starve_cnt_q == STARVE_LIM);
  assign grant_mem  = (state_q == IDLE) && mp.mem_req && !if_starved;
  // flush blocks the fetch grant: the address on if_addr is already stale.
  assign grant_if   = (state_q == IDLE) && !grant_mem && mp.if_req && !mp.flush;

  // Counts MEM grants that overtook a waiting fetch; any grant that leaves no
  // fetch waiting restarts the count.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (grant_mem) begin
      starve_cnt_d = mp.if_req ? sat_inc(starve_cnt_q) : '0;
    end else if (grant_if) begin
      starve_cnt_d = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Response path (combinational in the ack cycle)
  // ---------------------------------------------------------------------------
  assign if_ack      = (state_q == BUSY_IF)  && mp.bus_ack;
  assign mem_ack     = (state_q == BUSY_MEM) && mp.bus_ack;
  // A fetch flushed earlier (drop_q) or in the ack cycle itself is swallowed.
  assign if_ready_w  = if_ack && !drop_q && !mp.flush;
  assign mem_ready_w = mem_ack;

  assign mp.if_ready  = if_ready_w;
  assign mp.if_rdata  = if_ready_w  ? mp.bus_rdata : '0;
  assign mp.mem_ready = mem_ready_w;
  assign mp.mem_rdata = mem_ready_w ? mp.bus_rdata : '0;

  assign mp.stall_IF  = mp.if_req  && !if_ready_w;
  assign mp.stall_MEM = mp.mem_req && !mem_ready_w;

  assign mp.bus_valid = bus_valid_q;
  assign mp.bus_we    = bus_we_q;
  assign mp.bus_wstrb = bus_wstrb_q;
  assign mp.bus_addr  = bus_addr_q;
  assign mp.bus_wdata = bus_wdata_q;

  // ---------------------------------------------------------------------------
  // Control FSM with registered bus request
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      bus_valid_q  <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_wstrb_q  <= '0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      starve_cnt_q <= '0;
      drop_q       <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      case (state_q)
        IDLE: begin
          if (grant_mem) begin
            state_q     <= BUSY_MEM;
            bus_valid_q <= 1'b1;
            bus_we_q    <= mp.mem_we;
            // Loads never carry byte enables onto the bus.
            bus_wstrb_q <= mp.mem_we ? mp.mem_wstrb : '0;
            bus_addr_q  <= mp.mem_addr;
            bus_wdata_q <= mp.mem_wdata;
          end else if (grant_if) begin
            state_q     <= BUSY_IF;
            bus_valid_q <= 1'b1;
            bus_we_q    <= 1'b0;
            bus_wstrb_q <= '0;
            bus_addr_q  <= mp.if_addr;
            bus_wdata_q <= '0;
          end
        end
        BUSY_IF: begin
          if (mp.bus_ack) begin
            state_q     <= IDLE;
            bus_valid_q <= 1'b0;
            drop_q      <= 1'b0;
          end else if (mp.flush) begin
            // The bus access cannot be cancelled; remember to discard it.
            drop_q      <= 1'b1;
          end
        end
        BUSY_MEM: begin
          if (mp.bus_ack) begin
            state_q     <= IDLE;
            bus_valid_q <= 1'b0;
            drop_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          bus_valid_q <= 1'b0;
          drop_q      <= 1'b0;
        end
      endcase
    end
  end

endmodule
